// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // A programmed weight of zero still grants one beat.
  function automatic logic [31:0] norm_weight(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Two-pass round-robin priority search: lowest active index at or above ptr,
// otherwise the lowest active index overall. Excluded requesters never win.
module rr_pick
  import wrr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic [NUM_REQ-1:0] excl,
  output logic               found,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    id
);

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] upper;
  logic               found_hi;
  logic               found_lo;
  logic [ID_W-1:0]    id_hi;
  logic [ID_W-1:0]    id_lo;

  always_comb begin
    cand     = req & ~excl;
    upper    = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    id_hi    = '0;
    id_lo    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper[i] = cand[i] && (i >= int'(ptr));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (upper[i] && !found_hi) begin
        found_hi = 1'b1;
        id_hi    = ID_W'(i);
      end
      if (cand[i] && !found_lo) begin
        found_lo = 1'b1;
        id_lo    = ID_W'(i);
      end
    end
    found = found_hi | found_lo;
    id    = found_hi ? id_hi : id_lo;
    gnt   = found ? (NUM_REQ'(1) << id) : '0;
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with burst hold and back-to-back handover.
// Optional macro WRR_LOCK_EN adds lock_i to pin the current owner's grant.
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WEIGHT_W = 4,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_i,
  input  logic                         accept_i,
`ifdef WRR_LOCK_EN
  input  logic [NUM_REQ-1:0]           lock_i,
`endif
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic                         gnt_valid_o,
  output logic [ID_W-1:0]              gnt_id_o
);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 vld_q;

  logic                 found_a, found_b;
  logic [NUM_REQ-1:0]   gnt_a, gnt_b;
  logic [ID_W-1:0]      id_a, id_b;
  logic [ID_W-1:0]      ptr_rel;
  logic [NUM_REQ-1:0]   excl_rel;
  logic [WEIGHT_W-1:0]  weight_a, weight_b;
  logic                 lock_hold;
  logic                 release_now;

`ifdef WRR_LOCK_EN
  assign lock_hold = lock_i[owner_q] & req_i[owner_q];
`else
  assign lock_hold = 1'b0;
`endif

  assign ptr_rel  = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  // The releasing owner only competes again when nobody else is asking.
  assign excl_rel = ((req_i & ~gnt_q) != '0) ? gnt_q : '0;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick_idle (
    .req   (req_i),
    .ptr   (ptr_q),
    .excl  ({NUM_REQ{1'b0}}),
    .found (found_a),
    .gnt   (gnt_a),
    .id    (id_a)
  );

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick_release (
    .req   (req_i),
    .ptr   (ptr_rel),
    .excl  (excl_rel),
    .found (found_b),
    .gnt   (gnt_b),
    .id    (id_b)
  );

  assign weight_a = weight_i[int'(id_a)*WEIGHT_W +: WEIGHT_W];
  assign weight_b = weight_i[int'(id_b)*WEIGHT_W +: WEIGHT_W];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    credit_d    = credit_q;
    gnt_d       = gnt_q;
    release_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_a) begin
          state_d  = GRANT;
          owner_d  = id_a;
          gnt_d    = gnt_a;
          credit_d = WEIGHT_W'(norm_weight(32'(weight_a)));
        end
      end
      GRANT: begin
        // A dropped request wins over any beat offered in the same cycle.
        if (!req_i[owner_q]) begin
          release_now = 1'b1;
        end else if (accept_i) begin
          if (credit_q == WEIGHT_W'(1)) begin
            release_now = !lock_hold;
          end else begin
            credit_d = credit_q - 1'b1;
          end
        end
        if (release_now) begin
          ptr_d = ptr_rel;
          if (found_b) begin
            owner_d  = id_b;
            gnt_d    = gnt_b;
            credit_d = WEIGHT_W'(norm_weight(32'(weight_b)));
          end else begin
            state_d  = IDLE;
            owner_d  = '0;
            gnt_d    = '0;
            credit_d = '0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        owner_d  = '0;
        gnt_d    = '0;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      credit_q <= '0;
      gnt_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      gnt_q    <= gnt_d;
      vld_q    <= |gnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = vld_q;
  assign gnt_id_o    = owner_q;

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
- Parametrised weighted round-robin arbiter with burst hold, for NUM_REQ requesters sharing one downstream port.
- A winner holds the grant for up to its programmed weight in accepted beats, or until it drops its request.
- On release, priority rotates to the next index after the previous owner.
- Next-generation replacement for the fixed 4-way single-cycle round-robin arbiter; sits in front of shared buses and FIFOs.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WEIGHT_W, 4, width of each per-requester weight / credit counter.
- ID_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req_i  input  NUM_REQ  request per requester; level, held until served.
- weight_i  input  NUM_REQ*WEIGHT_W  flattened weights; slice k is requester k. Value 0 is treated as 1.
- accept_i  input  1  downstream consumed the granted beat this cycle.
- gnt_o  output  NUM_REQ  one-hot grant, registered.
- gnt_valid_o  output  1  OR of gnt_o, registered.
- gnt_id_o  output  ID_W  binary index of the owner; 0 when gnt_valid_o=0.

Behaviour:
- Reset (async, immediate, including mid-burst): gnt_o=0, gnt_valid_o=0, gnt_id_o=0, ptr=0, credit=0, state=IDLE.
- State: two-state FSM (IDLE, GRANT), plus registers ptr (ID_W), owner (ID_W) and credit (WEIGHT_W).
- Pick function: the lowest-index active request at index >= ptr. If none exists there, the lowest-index active request overall (wrap-around).
- IDLE:
  - If |req_i, the next cycle enters GRANT with owner=pick and credit=max(weight[pick],1).
  - Request-to-grant latency is exactly 1 cycle.
- GRANT: gnt_o=onehot(owner). Each cycle, exactly one of the following applies, in priority order:
  1. req_i[owner]=0 → release. Any accept_i in that cycle is ignored; the beat is not counted.
  2. accept_i=1 and credit==1 → release after this beat.
  3. accept_i=1 and credit>1 → credit decrements by 1; grant held.
  4. accept_i=0 → hold; credit unchanged.
- Release:
  - ptr <= (owner+1) mod NUM_REQ.
  - Pick is re-evaluated with the new ptr against the current req_i, excluding the releasing owner unless it is the only requester.
  - If a winner exists, the next cycle is GRANT with the new owner and a fresh credit. There is no idle bubble.
  - Otherwise the next cycle is IDLE with gnt_o=0.
- Sole requester: it re-wins immediately with a fresh credit, and ptr still advances.
- Weight sampling: weight_i is sampled only when a grant is issued. Changes during a burst take effect at the next grant.
- Credit arithmetic: never underflows. Maximum burst is 2^WEIGHT_W-1 beats.
- Invariants: gnt_o is always one-hot or zero. No grant is issued to a requester with req_i=0 in the issuing cycle.

Optional Feature:
- Macro WRR_LOCK_EN.
- Defined:
  - Adds port lock_i (input, NUM_REQ).
  - While lock_i[owner]=1 and req_i[owner]=1, credit-exhaustion release is suppressed. Credit saturates at 1 and the grant is held indefinitely.
  - Request drop still releases.
  - When lock_i[owner] deasserts with credit==1, the next accepted beat releases.
- Not defined: no lock_i port; behaviour is exactly as above.

Decomposition:
- Package wrr_arbiter_pkg: state enum (IDLE, GRANT) and a weight-normalise function (0→1).
- Sub-module rr_pick, parameter NUM_REQ:
  - Inputs: req, ptr, exclude mask.
  - Outputs: found, one-hot gnt, binary id.
  - Implements the masked/unmasked two-pass priority search.
  - Instantiated twice: initial pick, and post-release pick.

Test Plan:
1. Reset mid-burst: assert reset while gnt_o=0010 → gnt_o=0000 immediately; after release, req_i=0100 → gnt_o=0100 one cycle later, gnt_id_o=2.
2. All weights 1, req_i=1111, accept_i=1 constantly → grants rotate 0001, 0010, 0100, 1000, 0001 with no idle cycles.
3. weight = {3,1,2,1} (req3..req0), req_i=1111, accept_i=1 → grant sequence per owner: 0×1, 1×2, 2×1, 3×3 beats, then back to 0.
4. Owner 1 granted with weight 4 and accept_i low for 5 cycles → grant held, credit stays 4; then req_i[1] drops → next cycle grant moves to requester 2 (req_i=0101 → gnt_o=0100).
5. Sole requester: req_i=1000, weight 2, accept_i=1 → gnt_o=1000 held continuously; ptr wraps to 0; no gap in gnt_valid_o.
6. WRR_LOCK_EN: owner 0, weight 1, lock_i=0001, accept_i=1 for 10 cycles → grant held throughout; drop lock_i → released after one more accepted beat, then requester 1 granted.
